// File: rtl/method_test_sequencer_if.sv
// Handshake and status bundle between the method test sequencer and the
// harness that hosts the generated test methods.
interface method_test_sequencer_if #(
  parameter int unsigned NUM_TESTS = 4,
  parameter int unsigned IDX_W     = (NUM_TESTS > 32'd1) ? $clog2(NUM_TESTS) : 32'd1
);
  logic                 start;
  logic [NUM_TESTS-1:0] test_req;
  logic [NUM_TESTS-1:0] test_busy;
  logic [NUM_TESTS-1:0] test_return;
  logic                 running;
  logic                 done;
  logic                 pass;
  logic [NUM_TESTS-1:0] fail_mask;
  logic [NUM_TESTS-1:0] timeout_mask;
  logic [IDX_W-1:0]     current_idx;

  // Sequencer side: launches methods and publishes the verdict.
  modport master (
    input  start,
    input  test_busy,
    input  test_return,
    output test_req,
    output running,
    output done,
    output pass,
    output fail_mask,
    output timeout_mask,
    output current_idx
  );

  // Harness side: hosts the methods and kicks off runs.
  modport slave (
    output start,
    output test_busy,
    output test_return,
    input  test_req,
    input  running,
    input  done,
    input  pass,
    input  fail_mask,
    input  timeout_mask,
    input  current_idx
  );
endinterface

// File: rtl/method_test_sequencer.sv
// Launches each generated test method in turn via req/busy/return, guards every
// step with a watchdog, and reports per-test fail/timeout plus an overall pass.
module method_test_sequencer #(
  parameter int unsigned NUM_TESTS   = 4,
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned RUN_TIMEOUT = 200000000,
  parameter int unsigned CNT_W       = 32
) (
  input logic                     clk,
  input logic                     reset,
  method_test_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_TESTS > 32'd1) ? $clog2(NUM_TESTS) : 32'd1;

  // Terminal counts; each watchdog fires on equality so it never overshoots.
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'((START_DELAY > 32'd0) ? START_DELAY - 32'd1 : 32'd0);
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'((ACK_TIMEOUT > 32'd0) ? ACK_TIMEOUT - 32'd1 : 32'd0);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'((RUN_TIMEOUT > 32'd0) ? RUN_TIMEOUT - 32'd1 : 32'd0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_nxt_s;
  logic [NUM_TESTS-1:0] fail_r;
  logic [NUM_TESTS-1:0] fail_nxt_s;
  logic [NUM_TESTS-1:0] tmo_r;
  logic [NUM_TESTS-1:0] tmo_nxt_s;
  logic [NUM_TESTS-1:0] req_s;
  logic                 running_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 busy_sel_s;
  logic                 ret_sel_s;

  // Only the lane of the test in progress is ever looked at.
  assign busy_sel_s = bus.test_busy[idx_r];
  assign ret_sel_s  = bus.test_return[idx_r];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (bus.start) begin
          state_nxt_s = (START_DELAY == 32'd0) ? ST_ISSUE : ST_DELAY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DELAY: begin
        if (cnt_r == DLY_LAST) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_DELAY;
        end
      end
      ST_ISSUE: begin
        if (!busy_sel_s) begin
          state_nxt_s = ST_WAIT_ACK;
        end else if (cnt_r == ACK_LAST) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_ACK: begin
        // A late ack landing on the timeout cycle still counts as an ack.
        if (busy_sel_s) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r == ACK_LAST) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_sel_s) begin
          state_nxt_s = ST_NEXT;
        end else if (cnt_r == RUN_LAST) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state outputs and datapath updates (counter, index, verdict masks).
  always_comb begin
    cnt_nxt_s  = cnt_r;
    idx_nxt_s  = idx_r;
    fail_nxt_s = fail_r;
    tmo_nxt_s  = tmo_r;
    req_s      = '0;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (bus.start) begin
          cnt_nxt_s  = '0;
          idx_nxt_s  = '0;
          fail_nxt_s = '0;
          tmo_nxt_s  = '0;
        end else begin
          cnt_nxt_s  = cnt_r;
        end
      end
      ST_DELAY: begin
        if (cnt_r == DLY_LAST) begin
          cnt_nxt_s = '0;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_ISSUE: begin
        // A method still busy from an earlier run is never re-launched.
        if (!busy_sel_s) begin
          req_s[idx_r] = 1'b1;
          cnt_nxt_s    = '0;
        end else if (cnt_r == ACK_LAST) begin
          fail_nxt_s[idx_r] = 1'b1;
          tmo_nxt_s[idx_r]  = 1'b1;
          cnt_nxt_s         = '0;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_WAIT_ACK: begin
        if (busy_sel_s) begin
          cnt_nxt_s = '0;
        end else if (cnt_r == ACK_LAST) begin
          fail_nxt_s[idx_r] = 1'b1;
          tmo_nxt_s[idx_r]  = 1'b1;
          cnt_nxt_s         = '0;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_sel_s) begin
          fail_nxt_s[idx_r] = fail_r[idx_r] | ~ret_sel_s;
          cnt_nxt_s         = '0;
        end else if (cnt_r == RUN_LAST) begin
          fail_nxt_s[idx_r] = 1'b1;
          tmo_nxt_s[idx_r]  = 1'b1;
          cnt_nxt_s         = '0;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_NEXT: begin
        cnt_nxt_s = '0;
        if (idx_r == IDX_LAST) begin
          idx_nxt_s = idx_r;
        end else begin
          idx_nxt_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        cnt_nxt_s  = '0;
        idx_nxt_s  = '0;
        fail_nxt_s = '0;
        tmo_nxt_s  = '0;
      end
    endcase
  end

  // Datapath and registered status outputs, all keyed off the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      idx_r     <= '0;
      fail_r    <= '0;
      tmo_r     <= '0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      fail_r    <= fail_nxt_s;
      tmo_r     <= tmo_nxt_s;
      running_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FINISH);
      done_r    <= (state_nxt_s == ST_FINISH);
      pass_r    <= (state_nxt_s == ST_FINISH) && ~|fail_nxt_s;
    end
  end

  assign bus.test_req     = req_s;
  assign bus.running      = running_r;
  assign bus.done         = done_r;
  assign bus.pass         = pass_r;
  assign bus.fail_mask    = fail_r;
  assign bus.timeout_mask = tmo_r;
  assign bus.current_idx  = idx_r;

endmodule

// File: tb/tb_method_test_sequencer.sv
// Directed bench for method_test_sequencer: table of full runs against a small
// method model, plus hand sequences for reset abort and ignored disturbances.
module tb_method_test_sequencer;

  localparam int NT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  method_test_sequencer_if #(.NUM_TESTS(NT)) ifc ();

  method_test_sequencer #(
    .NUM_TESTS  (NT),
    .START_DELAY(100),
    .ACK_TIMEOUT(16),
    .RUN_TIMEOUT(1000),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  typedef struct {
    logic [1:0] ret;
    logic [1:0] noack;
    logic [1:0] fvr;
    int         dur;
    int         ack;
    logic       exp_pass;
    logic [1:0] exp_fail;
    logic [1:0] exp_tmo;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] mbusy, gl, req_seen, cfg_ret, cfg_noack, cfg_fvr;
  int wait_c[NT], left_c[NT], req_cnt[NT];
  int cfg_dur, cfg_ack;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ret, input logic [1:0] noack,
                              input logic [1:0] fvr, input int dur, input int ack,
                              input logic ep, input logic [1:0] ef,
                              input logic [1:0] et, input int ed);
    vec_t v;
    v.ret = ret; v.noack = noack; v.fvr = fvr; v.dur = dur; v.ack = ack;
    v.exp_pass = ep; v.exp_fail = ef; v.exp_tmo = et; v.exp_done = ed;
    return v;
  endfunction

  // Method model: busy rises `ack` cycles after req, stays high `dur` cycles.
  task automatic model_step();
    req_seen = ifc.test_req;
    for (int i = 0; i < NT; i++) begin
      if (req_seen[i]) begin
        req_cnt[i]++;
        wait_c[i] = cfg_ack;
      end else if (wait_c[i] > 0) begin
        wait_c[i]--;
        if (wait_c[i] == 0 && !cfg_noack[i]) begin
          mbusy[i]  = 1'b1;
          left_c[i] = cfg_dur;
        end
      end else if (mbusy[i] && !cfg_fvr[i]) begin
        left_c[i]--;
        if (left_c[i] == 0) mbusy[i] = 1'b0;
      end
    end
    ifc.test_busy   = mbusy | gl;
    ifc.test_return = cfg_ret;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic model_clear(input vec_t v);
    cfg_ret = v.ret; cfg_noack = v.noack; cfg_fvr = v.fvr;
    cfg_dur = v.dur; cfg_ack = v.ack;
    mbusy = 2'b00; gl = 2'b00; req_seen = 2'b00;
    for (int i = 0; i < NT; i++) begin
      wait_c[i] = 0; left_c[i] = 0; req_cnt[i] = 0;
    end
    ifc.test_busy   = 2'b00;
    ifc.test_return = cfg_ret;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},     int'(ifc.test_req),     0);
    chk({tag, "_running"}, int'(ifc.running),      0);
    chk({tag, "_done"},    int'(ifc.done),         0);
    chk({tag, "_pass"},    int'(ifc.pass),         0);
    chk({tag, "_fail"},    int'(ifc.fail_mask),    0);
    chk({tag, "_tmo"},     int'(ifc.timeout_mask), 0);
    chk({tag, "_idx"},     int'(ifc.current_idx),  0);
  endtask

  // mode 0: plain run, 1: reset during WAIT_DONE of test 0, 2: stray start + busy glitches
  task automatic run(input vec_t v, input int mode, input string tag);
    int k;
    int first_req0;
    int done_k;
    model_clear(v);
    tick();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    k = 1;
    chk({tag, "_done_low_after_start"}, int'(ifc.done), 0);
    chk({tag, "_running_after_start"}, int'(ifc.running), 1);
    first_req0 = -1;
    done_k     = -1;
    while (k < 4000 && done_k < 0) begin
      if (mode == 1 && k == 110) begin
        chk({tag, "_req0_cycle"}, first_req0, 101);
        chk({tag, "_running_mid"}, int'(ifc.running), 1);
        #2 reset = 1'b1;
        #1 chk_zero({tag, "_async"});
        tick();
        tick();
        reset = 1'b0;
        model_clear(v);
        return;
      end
      if (mode == 2) begin
        ifc.start = (k == 50 || k == 120);
        gl = (k >= 105 && k < 140) ? {~gl[1], 1'b0} : 2'b00;
      end
      tick();
      k++;
      if (req_seen[0] && first_req0 < 0) first_req0 = k;
      if (ifc.done) done_k = k;
    end
    ifc.start = 1'b0;
    if (done_k < 0) chk({tag, "_done_within_budget"}, 0, 1);
    chk({tag, "_req0_cycle"},   first_req0,              101);
    chk({tag, "_done_cycle"},   done_k,                  v.exp_done);
    chk({tag, "_pass"},         int'(ifc.pass),          int'(v.exp_pass));
    chk({tag, "_fail_mask"},    int'(ifc.fail_mask),     int'(v.exp_fail));
    chk({tag, "_timeout_mask"}, int'(ifc.timeout_mask),  int'(v.exp_tmo));
    chk({tag, "_running_end"},  int'(ifc.running),       0);
    chk({tag, "_idx_end"},      int'(ifc.current_idx),   NT - 1);
    chk({tag, "_req0_count"},   req_cnt[0],              1);
    chk({tag, "_req1_count"},   req_cnt[1],              1);
    tick();
    chk({tag, "_done_held"},    int'(ifc.done),          1);
  endtask

  initial begin
    //           ret    noack  fvr    dur ack pass fail   tmo    done
    vecs[0] = mk(2'b11, 2'b00, 2'b00, 50, 1,  1'b1, 2'b00, 2'b00, 207);
    vecs[1] = mk(2'b01, 2'b00, 2'b00, 50, 1,  1'b0, 2'b10, 2'b00, 207);
    vecs[2] = mk(2'b11, 2'b01, 2'b00, 50, 1,  1'b0, 2'b01, 2'b01, 172);
    vecs[3] = mk(2'b10, 2'b00, 2'b00, 5,  1,  1'b0, 2'b01, 2'b00, 117);
    vecs[4] = mk(2'b11, 2'b00, 2'b00, 5,  16, 1'b1, 2'b00, 2'b00, 147);
    vecs[5] = mk(2'b11, 2'b00, 2'b10, 50, 1,  1'b0, 2'b10, 2'b10, 1157);

    reset     = 1'b1;
    ifc.start = 1'b0;
    model_clear(vecs[0]);
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk_zero("post_release");

    for (int i = 0; i < 6; i++) begin
      run(vecs[i], 0, $sformatf("v%0d", i));
    end
    run(vecs[0], 0, "rerun_after_timeout");
    run(vecs[0], 1, "abort");
    run(vecs[0], 0, "after_abort");
    run(vecs[0], 2, "disturb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
